// File: rtl/fifo_uart_tx.sv
//------------------------------------------------------------------------------
// Module      : fifo_uart_tx
// Description : Drains a byte FIFO and transmits each byte as 8N1 serial,
//               LSB first. Define FIFO_UART_TX_PARITY_EN for an even-parity bit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] dout,
    output logic       re,
    output logic       txd,
    output logic       busy
);

    localparam int              c_BW        = $clog2(CLKS_PER_BIT);
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_BAUD_ONE  = c_BW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    state_t          r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic [c_BW-1:0] r_baud;
    logic            r_txd;
    logic            r_busy;
`ifdef FIFO_UART_TX_PARITY_EN
    logic            r_parity;
`endif

    logic w_bit_end;

    assign w_bit_end = (r_baud == c_BAUD_LAST);

    // Gated by rst so the FIFO is never popped while the block is held in reset.
    assign re   = (r_state == ST_IDLE) && !empty && !rst;
    assign txd  = r_txd;
    assign busy = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= 8'd0;
            r_bitcnt <= 3'd0;
            r_baud   <= '0;
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (!empty) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    r_shift  <= dout;
                    r_bitcnt <= 3'd0;
                    r_baud   <= '0;
                    r_txd    <= 1'b0;
                    r_state  <= ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
                    r_parity <= ^dout;
`endif
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_txd   <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud   <= '0;
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            r_txd   <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            // Next bit is already sitting one position up.
                            r_txd <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end

`ifdef FIFO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_txd   <= 1'b1;
                        r_state <= ST_STOP;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx with a queue-based FIFO
//               and a frame-level expected-waveform model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_uart_tx;

    localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * C;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       empty = 1'b1;
    logic [7:0] dout  = 8'd0;
    logic       re;
    logic       txd;
    logic       busy;

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst   (rst),
        .empty (empty),
        .dout  (dout),
        .re    (re),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO with registered read data and registered empty flag
    logic [7:0] fq[$];
    logic [7:0] pend[$];
    logic [7:0] mref[$];

    always @(posedge clk) begin
        if (re && fq.size() > 0) dout <= fq.pop_front();
        while (pend.size() > 0) fq.push_back(pend.pop_front());
        empty <= (fq.size() == 0);
    end

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected per-cycle outputs of frames already scheduled
    typedef struct packed {
        logic re;
        logic txd;
        logic busy;
    } exp_t;

    exp_t eq[$];
    int   re_q[$];
    logic txd_h  [0:8191];
    logic busy_h [0:8191];

    task automatic build_frame(input logic [7:0] b);
        logic l;
        eq.push_back({1'b0, 1'b1, 1'b1});
        for (int k = 0; k < NBITS; k++) begin
            if (k == 0)                      l = 1'b0;
            else if (k <= 8)                 l = b[k-1];
            else if (k == 9 && NBITS == 11)  l = ^b;
            else                             l = 1'b1;
            for (int j = 0; j < C; j++) eq.push_back({1'b0, l, 1'b1});
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc < 8192) begin
                txd_h[cyc]  = txd;
                busy_h[cyc] = busy;
            end
            if (re) re_q.push_back(cyc);
            if (rst) begin
                eq.delete();
                check("rst_re",   32'(re),   32'd0);
                check("rst_txd",  32'(txd),  32'd1);
                check("rst_busy", 32'(busy), 32'd0);
            end else if (eq.size() == 0) begin
                check("idle_re",   32'(re),   32'(!empty));
                check("idle_txd",  32'(txd),  32'd1);
                check("idle_busy", 32'(busy), 32'd0);
                if (!empty && mref.size() > 0) build_frame(mref.pop_front());
            end else begin
                e = eq.pop_front();
                check("frame_re",   32'(re),   32'(e.re));
                check("frame_txd",  32'(txd),  32'(e.txd));
                check("frame_busy", 32'(busy), 32'(e.busy));
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        #1;
        pend.push_back(b);
        mref.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk); #1;
        while (k < budget && !(eq.size() == 0 && mref.size() == 0 && empty && !busy)) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= budget) begin
            nvec++;
            nmis++;
            $display("FAIL wait_idle: still busy after %0d cycles (cycle %0d)", budget, cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic hist_txd(input int i);
        return (i >= 0 && i < 8192) ? txd_h[i] : 1'bx;
    endfunction

    function automatic logic [7:0] decode(input int n);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = hist_txd(n + 2 + C * (k + 1) + C / 2);
        return b;
    endfunction

    function automatic int count_busy(input int a, input int z);
        int c;
        c = 0;
        for (int i = a; i <= z; i++) if (i >= 0 && i < 8192 && busy_h[i] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        int s;
        int n;
        int t;
        logic [9:0] pat;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        check("reset_txd",  32'(txd),  32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_re",   32'(re),   32'd0);

        // Single byte 0x05
        s = re_q.size();
        write_byte(8'h05);
        wait_idle(200);
        check("single_re_count", 32'(re_q.size() - s), 32'd1);
        if (re_q.size() > s) begin
            n = re_q[s];
            pat = 10'b1000001010;
            check("single_busy_len", 32'(count_busy(n, n + FRAME + 5)), 32'(FRAME + 1));
            check("timing_txd_n1", 32'(hist_txd(n + 1)), 32'd1);
            check("timing_txd_n2", 32'(hist_txd(n + 2)), 32'd0);
            for (int i = 0; i < 9; i++)
                check("single_bit", 32'(hist_txd(n + 2 + C * i + C / 2)), 32'(pat[i]));
            check("single_stop", 32'(hist_txd(n + 2 + C * (NBITS - 1) + C / 2)), 32'd1);
            check("single_byte", 32'(decode(n)), 32'h05);
        end

        // Back-to-back 0x06, 0x07, 0x08
        s = re_q.size();
        write_byte(8'h06);
        write_byte(8'h07);
        write_byte(8'h08);
        wait_idle(600);
        check("b2b_re_count", 32'(re_q.size() - s), 32'd3);
        if (re_q.size() >= s + 3) begin
            check("b2b_spacing1", 32'(re_q[s+1] - re_q[s]),   32'(FRAME + 2));
            check("b2b_spacing2", 32'(re_q[s+2] - re_q[s+1]), 32'(FRAME + 2));
            check("b2b_byte0", 32'(decode(re_q[s])),   32'h06);
            check("b2b_byte1", 32'(decode(re_q[s+1])), 32'h07);
            check("b2b_byte2", 32'(decode(re_q[s+2])), 32'h08);
            t = re_q[s+1];
            check("b2b_gap0",  32'(hist_txd(t)),     32'd1);
            check("b2b_gap1",  32'(hist_txd(t + 1)), 32'd1);
            check("b2b_start", 32'(hist_txd(t + 2)), 32'd0);
        end

        // Empty FIFO for 200 cycles
        s = re_q.size();
        t = cyc;
        repeat (200) @(negedge clk);
        #1;
        check("empty_no_re",   32'(re_q.size() - s),          32'd0);
        check("empty_no_busy", 32'(count_busy(t, cyc - 1)),   32'd0);

        // Reset during DATA bit 3 of 0x0A, FIFO then holds 0x0B
        s = re_q.size();
        write_byte(8'h0A);
        for (int k = 0; k < 50 && re_q.size() == s; k++) @(negedge clk);
        check("rst_first_re", 32'(re_q.size() - s), 32'd1);
        if (re_q.size() > s) begin
            n = re_q[s];
            for (int k = 0; k < 60 && cyc < n + 2 + C * 4 + 1; k++) @(negedge clk);
            #1 rst = 1'b1;
            #1;
            check("rst_async_txd",  32'(txd),  32'd1);
            check("rst_async_busy", 32'(busy), 32'd0);
            write_byte(8'h0B);
            repeat (3) @(posedge clk);
            #2 rst = 1'b0;
            wait_idle(200);
            check("rst_re_count", 32'(re_q.size() - s), 32'd2);
            if (re_q.size() >= s + 2)
                check("rst_next_byte", 32'(decode(re_q[s+1])), 32'h0B);
        end

`ifdef FIFO_UART_TX_PARITY_EN
        s = re_q.size();
        write_byte(8'h07);
        write_byte(8'h05);
        wait_idle(400);
        check("par_re_count", 32'(re_q.size() - s), 32'd2);
        if (re_q.size() >= s + 2) begin
            check("par_bit0", 32'(hist_txd(re_q[s]   + 2 + C * 9 + C / 2)), 32'd1);
            check("par_bit1", 32'(hist_txd(re_q[s+1] + 2 + C * 9 + C / 2)), 32'd0);
            check("par_spacing", 32'(re_q[s+1] - re_q[s]), 32'd46);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
